// File: rtl/calc_pkg.sv
// Shared definitions for the parametrised calculator engine.
// Holds FSM state codes, operator codes, numpad key codes, button bit
// positions, and helpers that depend only on the operand digit count:
// the largest DIGITS-digit decimal value and the decimal digit count of a value.
package calc_pkg;

    typedef enum logic [2:0] {
        S_NUM1   = 3'd0,
        S_OP     = 3'd1,
        S_NUM2   = 3'd2,
        S_CALC   = 3'd3,
        S_RESULT = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    localparam logic [3:0] KEY_BACK  = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam int         NUM_KEYS  = 12;

    // Bit positions inside the packed button vector {R, L, D, U, C}
    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_L = 3;
    localparam int BTN_R = 4;

    // 10^digits - 1, for digits up to 19
    function automatic logic [63:0] max_value(input int digits);
        logic [63:0] m;
        m = 64'd1;
        for (int i = 0; i < 19; i++) begin
            if (i < digits) m = m * 64'd10;
        end
        return m - 64'd1;
    endfunction

    // Number of decimal digits in v (1 for v == 0), saturating at digits
    function automatic int digit_count(input logic [63:0] v, input int digits);
        int          n;
        logic [63:0] th;
        n  = 1;
        th = 64'd10;
        for (int i = 1; i < 19; i++) begin
            if (i < digits && v >= th) n = i + 1;
            th = th * 64'd10;
        end
        return n;
    endfunction

endpackage

// File: rtl/calc_iter_alu.sv
// Iterative multiply/divide unit with a fixed W-cycle latency.
// Ports: clk, reset_n (async active-low); start loads a/b and runs the first
// step on the same edge; op_div selects restoring divide (1) or shift-add
// multiply (0). busy is high while steps remain; done pulses for one cycle
// once all W steps have completed, with product or quotient/remainder valid.
module calc_iter_alu
    import calc_pkg::*;
#(
    parameter  int W     = 17,
    localparam int RES_W = 2 * W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] product,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder
);

    localparam int CW = $clog2(W + 1);

    logic             running_reg, done_reg, op_reg;
    logic [CW-1:0]    cnt_reg;
    logic [RES_W-1:0] acc_reg, mcand_reg;
    logic [W-1:0]     mplier_reg, quo_reg, rem_reg, dvsr_reg;

    // Step inputs come straight from the operands on the start edge so the
    // first iteration is not wasted on a load-only cycle.
    logic             cur_div;
    logic [RES_W-1:0] acc_in, mcand_in, acc_next;
    logic [W-1:0]     mplier_in, quo_in, rem_in, dvsr_in, rem_next, quo_next;
    logic [W:0]       trial;
    logic             fits;

    always_comb begin
        cur_div   = start ? op_div : op_reg;
        acc_in    = start ? '0 : acc_reg;
        mcand_in  = start ? RES_W'(a) : mcand_reg;
        mplier_in = start ? b : mplier_reg;
        quo_in    = start ? a : quo_reg;
        rem_in    = start ? '0 : rem_reg;
        dvsr_in   = start ? b : dvsr_reg;

        acc_next  = acc_in + (mplier_in[0] ? mcand_in : '0);

        // Restoring division: bring down the next dividend bit, subtract if it fits.
        // The partial remainder is always below the divisor, so W bits suffice after subtraction.
        trial     = {rem_in, quo_in[W-1]};
        fits      = (trial >= {1'b0, dvsr_in});
        rem_next  = fits ? (trial[W-1:0] - dvsr_in) : trial[W-1:0];
        quo_next  = {quo_in[W-2:0], fits};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            op_reg      <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            dvsr_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                op_reg      <= op_div;
                dvsr_reg    <= b;
                cnt_reg     <= CW'(W - 1);
                running_reg <= 1'b1;
            end else if (running_reg) begin
                cnt_reg <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    running_reg <= 1'b0;
                    done_reg    <= 1'b1;
                end
            end
            if (start || running_reg) begin
                if (cur_div) begin
                    quo_reg <= quo_next;
                    rem_reg <= rem_next;
                end else begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_in << 1;
                    mplier_reg <= mplier_in >> 1;
                end
            end
        end
    end

    assign busy      = running_reg;
    assign done      = done_reg;
    assign product   = acc_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/calc_engine_param.sv
// Parametrised calculator FSM: numpad/operator navigation from five debounced
// buttons, multi-digit decimal entry with backspace, ADD/SUB in one cycle and
// MUL/DIV through calc_iter_alu.
// Ports: clk, reset_n (async active-low), clear (sync soft clear),
// btnC/U/D/L/R button levels; outputs state, num1/num2 operands, result,
// remainder, result_neg, op_code, op_sel, key_sel, busy, result_valid, error.
module calc_engine_param
    import calc_pkg::*;
#(
    parameter  int DIGITS = 5,
    parameter  int W      = 17,
    localparam int RES_W  = 2 * W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             btnC,
    input  logic             btnU,
    input  logic             btnD,
    input  logic             btnL,
    input  logic             btnR,
    output logic [2:0]       state,
    output logic [W-1:0]     num1,
    output logic [W-1:0]     num2,
    output logic [RES_W-1:0] result,
    output logic [W-1:0]     remainder,
    output logic             result_neg,
    output logic [1:0]       op_code,
    output logic [1:0]       op_sel,
    output logic [3:0]       key_sel,
    output logic             busy,
    output logic             result_valid,
    output logic             error
);

    localparam int               CW      = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]    MAX_CNT = CW'(DIGITS);
    localparam logic [RES_W-1:0] MAX_VAL = RES_W'(max_value(DIGITS));
    localparam logic [W-1:0]     TEN     = W'(10);

    state_t           state_reg;
    logic [W-1:0]     num1_reg, num2_reg, remainder_reg;
    logic [CW-1:0]    count1_reg, count2_reg;
    logic [RES_W-1:0] result_reg;
    logic             neg_reg, valid_reg;
    logic [1:0]       op_code_reg, op_sel_reg;
    logic [3:0]       key_sel_reg, key_nav;
    logic [4:0]       btn, btn_q_reg, press;
    logic             ev_c, ev_u, ev_d, ev_l, ev_r;
    logic             soft_clear, alu_start, chain_ok;
    logic             alu_busy, alu_done;
    logic [RES_W-1:0] alu_product;
    logic [W-1:0]     alu_quotient, alu_remainder, digit;

    assign btn   = {btnR, btnL, btnD, btnU, btnC};
    assign press = btn & ~btn_q_reg;

    // Only the highest-priority press of a cycle survives: C > U > D > L > R
    assign ev_c = press[BTN_C];
    assign ev_u = press[BTN_U] & ~press[BTN_C];
    assign ev_d = press[BTN_D] & ~|press[BTN_U:BTN_C];
    assign ev_l = press[BTN_L] & ~|press[BTN_D:BTN_C];
    assign ev_r = press[BTN_R] & ~|press[BTN_L:BTN_C];

    assign digit      = W'(key_sel_reg);
    assign soft_clear = clear | (ev_c & ((state_reg == S_RESULT) | (state_reg == S_ERROR)));
    assign chain_ok   = !neg_reg && (result_reg <= MAX_VAL);
    // The divider is never started for a zero divisor; S_CALC diverts to S_ERROR instead.
    assign alu_start  = (state_reg == S_NUM2) && ev_c && (key_sel_reg == KEY_ENTER) &&
                        ((op_code_reg == OP_MUL) || ((op_code_reg == OP_DIV) && (num2_reg != '0)));

    // Numpad cursor on a 3x4 grid of 12 keys, wrapping in both directions
    always_comb begin
        key_nav = key_sel_reg;
        if (ev_l)      key_nav = (key_sel_reg == 4'd0)      ? KEY_ENTER : key_sel_reg - 4'd1;
        else if (ev_r) key_nav = (key_sel_reg == KEY_ENTER) ? 4'd0      : key_sel_reg + 4'd1;
        else if (ev_u) key_nav = (key_sel_reg < 4'd3)       ? key_sel_reg + 4'd9 : key_sel_reg - 4'd3;
        else if (ev_d) key_nav = (key_sel_reg > 4'd8)       ? key_sel_reg - 4'd9 : key_sel_reg + 4'd3;
    end

    calc_iter_alu #(.W(W)) u_alu (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (alu_start),
        .op_div    (op_code_reg == OP_DIV),
        .a         (num1_reg),
        .b         (num2_reg),
        .busy      (alu_busy),
        .done      (alu_done),
        .product   (alu_product),
        .quotient  (alu_quotient),
        .remainder (alu_remainder)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_NUM1;
            num1_reg      <= '0;
            num2_reg      <= '0;
            count1_reg    <= '0;
            count2_reg    <= '0;
            result_reg    <= '0;
            remainder_reg <= '0;
            neg_reg       <= 1'b0;
            op_code_reg   <= '0;
            op_sel_reg    <= '0;
            key_sel_reg   <= '0;
            valid_reg     <= 1'b0;
            btn_q_reg     <= '0;
        end else begin
            valid_reg <= 1'b0;
            btn_q_reg <= clear ? '0 : btn;
            if (soft_clear) begin
                state_reg     <= S_NUM1;
                num1_reg      <= '0;
                num2_reg      <= '0;
                count1_reg    <= '0;
                count2_reg    <= '0;
                result_reg    <= '0;
                remainder_reg <= '0;
                neg_reg       <= 1'b0;
                op_code_reg   <= '0;
                op_sel_reg    <= '0;
                key_sel_reg   <= '0;
            end else begin
                case (state_reg)
                    S_NUM1, S_NUM2: begin
                        key_sel_reg <= key_nav;
                        if (ev_c) begin
                            if (key_sel_reg < KEY_BACK) begin
                                if (state_reg == S_NUM1 && count1_reg < MAX_CNT) begin
                                    num1_reg   <= num1_reg * TEN + digit;
                                    count1_reg <= count1_reg + CW'(1);
                                end else if (state_reg == S_NUM2 && count2_reg < MAX_CNT) begin
                                    num2_reg   <= num2_reg * TEN + digit;
                                    count2_reg <= count2_reg + CW'(1);
                                end
                            end else if (key_sel_reg == KEY_BACK) begin
                                if (state_reg == S_NUM1) begin
                                    if (count1_reg != '0) begin
                                        num1_reg   <= num1_reg / TEN;
                                        count1_reg <= count1_reg - CW'(1);
                                    end
                                end else if (count2_reg != '0) begin
                                    num2_reg   <= num2_reg / TEN;
                                    count2_reg <= count2_reg - CW'(1);
                                end else begin
                                    state_reg <= S_OP;
                                end
                            end else begin
                                state_reg <= (state_reg == S_NUM1) ? S_OP : S_CALC;
                            end
                        end
                    end
                    S_OP: begin
                        if (ev_c) begin
                            op_code_reg <= op_sel_reg;
                            num2_reg    <= '0;
                            count2_reg  <= '0;
                            key_sel_reg <= '0;
                            state_reg   <= S_NUM2;
                        end else if (ev_u) begin
                            op_sel_reg <= op_sel_reg - 2'd1;
                        end else if (ev_d) begin
                            op_sel_reg <= op_sel_reg + 2'd1;
                        end
                    end
                    S_CALC: begin
                        case (op_code_reg)
                            OP_ADD: begin
                                result_reg    <= RES_W'(num1_reg) + RES_W'(num2_reg);
                                remainder_reg <= '0;
                                neg_reg       <= 1'b0;
                                valid_reg     <= 1'b1;
                                state_reg     <= S_RESULT;
                            end
                            OP_SUB: begin
                                result_reg    <= (num1_reg >= num2_reg) ? RES_W'(num1_reg - num2_reg)
                                                                        : RES_W'(num2_reg - num1_reg);
                                neg_reg       <= (num1_reg < num2_reg);
                                remainder_reg <= '0;
                                valid_reg     <= 1'b1;
                                state_reg     <= S_RESULT;
                            end
                            default: begin
                                if (op_code_reg == OP_DIV && num2_reg == '0) begin
                                    state_reg <= S_ERROR;
                                end else if (alu_done) begin
                                    result_reg    <= (op_code_reg == OP_DIV) ? RES_W'(alu_quotient) : alu_product;
                                    remainder_reg <= (op_code_reg == OP_DIV) ? alu_remainder : '0;
                                    neg_reg       <= 1'b0;
                                    valid_reg     <= 1'b1;
                                    state_reg     <= S_RESULT;
                                end else if (!alu_busy) begin
                                    // Iterative unit idle with no result pending: never wait forever
                                    state_reg <= S_ERROR;
                                end
                            end
                        endcase
                    end
                    S_RESULT: begin
                        if (ev_r && chain_ok) begin
                            num1_reg   <= result_reg[W-1:0];
                            count1_reg <= CW'(digit_count(64'(result_reg), DIGITS));
                            num2_reg   <= '0;
                            count2_reg <= '0;
                            state_reg  <= S_OP;
                        end
                    end
                    S_ERROR: begin
                        // Only C leaves this state, handled by soft_clear
                    end
                    default: state_reg <= S_NUM1;
                endcase
            end
        end
    end

    assign state        = state_reg;
    assign num1         = num1_reg;
    assign num2         = num2_reg;
    assign result       = result_reg;
    assign remainder    = remainder_reg;
    assign result_neg   = neg_reg;
    assign op_code      = op_code_reg;
    assign op_sel       = op_sel_reg;
    assign key_sel      = key_sel_reg;
    assign busy         = (state_reg == S_CALC);
    assign error        = (state_reg == S_ERROR);
    assign result_valid = valid_reg;

endmodule

// File: tb/tb_calc_engine_param.sv
// Scoreboard bench for calc_engine_param: expected results are queued when a
// calculation is launched and compared when result_valid pulses.
module tb_calc_engine_param;
    import calc_pkg::*;

    localparam int DIGITS = 5;
    localparam int W      = 17;
    localparam int RES_W  = 2 * W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic [4:0]       btn = '0;
    logic [2:0]       state;
    logic [W-1:0]     num1, num2, remainder;
    logic [RES_W-1:0] result;
    logic             result_neg, busy, result_valid, error;
    logic [1:0]       op_code, op_sel;
    logic [3:0]       key_sel;

    always #5 clk = ~clk;

    calc_engine_param #(.DIGITS(DIGITS), .W(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .btnC         (btn[BTN_C]),
        .btnU         (btn[BTN_U]),
        .btnD         (btn[BTN_D]),
        .btnL         (btn[BTN_L]),
        .btnR         (btn[BTN_R]),
        .state        (state),
        .num1         (num1),
        .num2         (num2),
        .result       (result),
        .remainder    (remainder),
        .result_neg   (result_neg),
        .op_code      (op_code),
        .op_sel       (op_sel),
        .key_sel      (key_sel),
        .busy         (busy),
        .result_valid (result_valid),
        .error        (error)
    );

    typedef struct {
        logic [63:0] res;
        logic [63:0] rem;
        logic        neg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;
    int   cur_key  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Result monitor: every result_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset_n && result_valid) begin
            n_pulses++;
            check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_eq("result", 64'(result), mon_e.res);
                check_eq("remainder", 64'(remainder), mon_e.rem);
                check_eq("result_neg", 64'(result_neg), 64'(mon_e.neg));
                $display("txn: result=%0d remainder=%0d neg=%0d", result, remainder, result_neg);
            end
        end
    end

    task automatic press(input int b);
        @(negedge clk) btn[b] = 1'b1;
        @(negedge clk) btn[b] = 1'b0;
    endtask

    task automatic goto_key(input int k);
        int guard = 0;
        while (cur_key != k && guard < NUM_KEYS) begin
            press(BTN_R);
            cur_key = (cur_key + 1) % NUM_KEYS;
            guard++;
        end
    endtask

    task automatic type_value(input longint v);
        int ds[$];
        if (v == 0) ds.push_back(0);
        while (v > 0) begin
            ds.push_front(int'(v % 10));
            v = v / 10;
        end
        foreach (ds[i]) begin
            goto_key(ds[i]);
            press(BTN_C);
        end
    endtask

    task automatic enter_key();
        goto_key(int'(KEY_ENTER));
        press(BTN_C);
    endtask

    // Launch from S_NUM2 and measure how long busy stays high
    task automatic run_calc(input int exp_busy, input string tag);
        int n = 0;
        goto_key(int'(KEY_ENTER));
        @(negedge clk) btn[BTN_C] = 1'b1;
        @(negedge clk) btn[BTN_C] = 1'b0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        check_eq({tag, "_state"}, 64'(state), 64'(S_RESULT));
        @(negedge clk);
        check_eq({tag, "_valid_pulse_width"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        int n;
        int pulses_before;

        // 1: reset and navigation wrap
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_state", 64'(state), 64'(S_NUM1));
        check_eq("rst_num1", 64'(num1), 64'd0);
        check_eq("rst_key_sel", 64'(key_sel), 64'd0);
        check_eq("rst_flags", 64'({busy, error, result_valid, result_neg}), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        cur_key = 0;
        press(BTN_L);
        cur_key = 11;
        check_eq("key_left_wrap", 64'(key_sel), 64'd11);
        goto_key(1);
        press(BTN_U);
        cur_key = 10;
        check_eq("key_up_wrap", 64'(key_sel), 64'd10);

        // 2: 123 ADD 45
        type_value(123);
        check_eq("add_num1", 64'(num1), 64'd123);
        enter_key();
        check_eq("add_state_op", 64'(state), 64'(S_OP));
        press(BTN_C);
        cur_key = 0;
        check_eq("add_state_num2", 64'(state), 64'(S_NUM2));
        type_value(45);
        check_eq("add_num2", 64'(num2), 64'd45);
        sb.push_back('{res: 64'd168, rem: 64'd0, neg: 1'b0});
        run_calc(1, "add");

        // 3: 99999 MUL 99999
        press(BTN_C);
        cur_key = 0;
        check_eq("clr_state", 64'(state), 64'(S_NUM1));
        type_value(99999);
        enter_key();
        press(BTN_D);
        press(BTN_D);
        check_eq("mul_op_sel", 64'(op_sel), 64'd2);
        press(BTN_C);
        cur_key = 0;
        type_value(99999);
        sb.push_back('{res: 64'd9999800001, rem: 64'd0, neg: 1'b0});
        run_calc(W, "mul");
        check_eq("mul_op_code", 64'(op_code), 64'(OP_MUL));

        // 4: 5 SUB 12, chain refused, then 7 DIV 0
        press(BTN_C);
        cur_key = 0;
        type_value(5);
        enter_key();
        press(BTN_D);
        press(BTN_C);
        cur_key = 0;
        type_value(12);
        sb.push_back('{res: 64'd7, rem: 64'd0, neg: 1'b1});
        run_calc(1, "sub");
        press(BTN_R);
        check_eq("sub_chain_ignored", 64'(state), 64'(S_RESULT));
        press(BTN_C);
        cur_key = 0;
        type_value(7);
        enter_key();
        press(BTN_D);
        press(BTN_D);
        press(BTN_D);
        press(BTN_C);
        cur_key = 0;
        enter_key();
        n = 0;
        while (!error && n < 10) begin
            n++;
            @(negedge clk);
        end
        check_eq("div0_latency", 64'(n), 64'd1);
        check_eq("div0_state", 64'(state), 64'(S_ERROR));
        check_eq("div0_busy", 64'(busy), 64'd0);
        press(BTN_C);
        cur_key = 0;
        check_eq("err_clear_state", 64'(state), 64'(S_NUM1));
        check_eq("err_clear_outputs", 64'({num1, num2, op_code, op_sel, key_sel, error}), 64'd0);
        check_eq("err_clear_result", 64'(result), 64'd0);

        // 5: digit limit, backspace, back to S_OP, simultaneous presses
        type_value(123456);
        check_eq("digit_limit", 64'(num1), 64'd12345);
        goto_key(int'(KEY_BACK));
        press(BTN_C);
        check_eq("backspace", 64'(num1), 64'd1234);
        enter_key();
        press(BTN_D);
        press(BTN_C);
        cur_key = 0;
        goto_key(int'(KEY_BACK));
        press(BTN_C);
        check_eq("back_to_op", 64'(state), 64'(S_OP));
        @(negedge clk) begin
            btn[BTN_C] = 1'b1;
            btn[BTN_U] = 1'b1;
        end
        @(negedge clk) btn = '0;
        cur_key = 0;
        check_eq("prio_state", 64'(state), 64'(S_NUM2));
        check_eq("prio_op_sel", 64'(op_sel), 64'd1);
        check_eq("prio_op_code", 64'(op_code), 64'(OP_SUB));
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        cur_key = 0;
        check_eq("soft_clear", 64'({state, num1, op_code, op_sel}), 64'd0);

        // 6: 100 DIV 7, chain, then reset during a divide
        type_value(100);
        enter_key();
        press(BTN_D);
        press(BTN_D);
        press(BTN_D);
        press(BTN_C);
        cur_key = 0;
        type_value(7);
        sb.push_back('{res: 64'd14, rem: 64'd2, neg: 1'b0});
        run_calc(W, "div");
        press(BTN_R);
        check_eq("chain_state", 64'(state), 64'(S_OP));
        check_eq("chain_num1", 64'(num1), 64'd14);
        press(BTN_C);
        cur_key = 0;
        type_value(3);
        goto_key(int'(KEY_ENTER));
        @(negedge clk) btn[BTN_C] = 1'b1;
        @(negedge clk) btn[BTN_C] = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("div_running", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_state", 64'(state), 64'(S_NUM1));
        check_eq("async_rst_busy", 64'(busy), 64'd0);
        check_eq("async_rst_num1", 64'(num1), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses_before = n_pulses;
        repeat (25) @(negedge clk);
        check_eq("no_valid_after_abort", 64'(n_pulses), 64'(pulses_before));
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
